// File: rtl/dcache_arbiter.sv
// rtl/dcache_arbiter.sv - load/store arbiter and sequencer for the single-ported data cache
module dcache_arbiter #(
  parameter int W_DATA     = 32,
  parameter int W_TAG      = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [W_TAG-1:0]  ld_tag,
  output logic              ld_ack,
  input  logic              st_req,
  input  logic [31:0]       st_addr,
  input  logic [W_DATA-1:0] st_data,
  output logic              st_ack,
  input  logic              flush,
  output logic              dc_valid,
  output logic              dc_opcode,
  output logic [31:0]       dc_address,
  output logic [W_DATA-1:0] dc_data,
  input  logic [W_DATA-1:0] dc_rdata,
  input  logic              dc_done,
  output logic              cdb_valid,
  output logic [W_DATA-1:0] cdb_data,
  output logic [W_TAG-1:0]  cdb_tag,
  input  logic              cdb_grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                kill_q, kill_d;
  logic                is_st_q, is_st_d;
  logic [W_TAG-1:0]    tag_q, tag_d;
  logic                ld_ack_q, ld_ack_d;
  logic                st_ack_q, st_ack_d;
  logic                dc_valid_q, dc_valid_d;
  logic                dc_opcode_q, dc_opcode_d;
  logic [31:0]         dc_address_q, dc_address_d;
  logic [W_DATA-1:0]   dc_data_q, dc_data_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [W_DATA-1:0]   cdb_data_q, cdb_data_d;
  logic [W_TAG-1:0]    cdb_tag_q, cdb_tag_d;
  logic                busy_q, busy_d;

  // A flushed load is invisible to arbitration for that cycle; stores still compete.
  logic ld_ok;
  logic grant_st;
  logic grant_ld;
  assign ld_ok    = ld_req && !flush;
  assign grant_st = st_req && (!ld_ok || (starve_cnt_q == STARVE_LIM));
  assign grant_ld = ld_ok && !grant_st;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    kill_d       = kill_q;
    is_st_d      = is_st_q;
    tag_d        = tag_q;
    ld_ack_d     = 1'b0;
    st_ack_d     = 1'b0;
    dc_valid_d   = dc_valid_q;
    dc_opcode_d  = dc_opcode_q;
    dc_address_d = dc_address_q;
    dc_data_d    = dc_data_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_data_d   = cdb_data_q;
    cdb_tag_d    = cdb_tag_q;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_st) begin
          state_d      = ACCESS;
          starve_cnt_d = 4'd0;
          is_st_d      = 1'b1;
          st_ack_d     = 1'b1;
          dc_valid_d   = 1'b1;
          dc_opcode_d  = 1'b1;
          dc_address_d = st_addr;
          dc_data_d    = st_data;
        end else if (grant_ld) begin
          state_d      = ACCESS;
          is_st_d      = 1'b0;
          ld_ack_d     = 1'b1;
          dc_valid_d   = 1'b1;
          dc_opcode_d  = 1'b0;
          dc_address_d = ld_addr;
          tag_d        = ld_tag;
          if (st_req && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end

      ACCESS: begin
        if (dc_done) begin
          dc_valid_d = 1'b0;
          // A flush arriving together with dc_done still kills the load.
          if (is_st_q || kill_q || flush) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d     = RESP;
            cdb_valid_d = 1'b1;
            cdb_data_d  = dc_rdata;
            cdb_tag_d   = tag_q;
          end
        end else if (!is_st_q && flush) begin
          kill_d = 1'b1;
        end
      end

      RESP: begin
        if (flush || cdb_grant) begin
          state_d     = IDLE;
          cdb_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        dc_valid_d  = 1'b0;
        cdb_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      kill_q       <= 1'b0;
      is_st_q      <= 1'b0;
      tag_q        <= '0;
      ld_ack_q     <= 1'b0;
      st_ack_q     <= 1'b0;
      dc_valid_q   <= 1'b0;
      dc_opcode_q  <= 1'b0;
      dc_address_q <= '0;
      dc_data_q    <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_tag_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
      is_st_q      <= is_st_d;
      tag_q        <= tag_d;
      ld_ack_q     <= ld_ack_d;
      st_ack_q     <= st_ack_d;
      dc_valid_q   <= dc_valid_d;
      dc_opcode_q  <= dc_opcode_d;
      dc_address_q <= dc_address_d;
      dc_data_q    <= dc_data_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_tag_q    <= cdb_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign ld_ack     = ld_ack_q;
  assign st_ack     = st_ack_q;
  assign dc_valid   = dc_valid_q;
  assign dc_opcode  = dc_opcode_q;
  assign dc_address = dc_address_q;
  assign dc_data    = dc_data_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_data   = cdb_data_q;
  assign cdb_tag    = cdb_tag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb/tb_dcache_arbiter.sv - directed and randomized self-checking bench for dcache_arbiter
module tb_dcache_arbiter;
  localparam int W_DATA     = 32;
  localparam int W_TAG      = 6;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [W_TAG-1:0]  ld_tag;
  logic              ld_ack;
  logic              st_req;
  logic [31:0]       st_addr;
  logic [W_DATA-1:0] st_data;
  logic              st_ack;
  logic              flush;
  logic              dc_valid;
  logic              dc_opcode;
  logic [31:0]       dc_address;
  logic [W_DATA-1:0] dc_data;
  logic [W_DATA-1:0] dc_rdata;
  logic              dc_done;
  logic              cdb_valid;
  logic [W_DATA-1:0] cdb_data;
  logic [W_TAG-1:0]  cdb_tag;
  logic              cdb_grant;
  logic              busy;

  always #5 clk = ~clk;

  dcache_arbiter #(
    .W_DATA(W_DATA),
    .W_TAG(W_TAG),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld_req(ld_req),
    .ld_addr(ld_addr),
    .ld_tag(ld_tag),
    .ld_ack(ld_ack),
    .st_req(st_req),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_ack(st_ack),
    .flush(flush),
    .dc_valid(dc_valid),
    .dc_opcode(dc_opcode),
    .dc_address(dc_address),
    .dc_data(dc_data),
    .dc_rdata(dc_rdata),
    .dc_done(dc_done),
    .cdb_valid(cdb_valid),
    .cdb_data(cdb_data),
    .cdb_tag(cdb_tag),
    .cdb_grant(cdb_grant),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic quiet_inputs();
    ld_req    = 1'b0;
    ld_addr   = '0;
    ld_tag    = '0;
    st_req    = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    flush     = 1'b0;
    dc_rdata  = '0;
    dc_done   = 1'b0;
    cdb_grant = 1'b0;
  endtask

  // Minimum-latency load with the result held for `hold` cycles before cdb_grant.
  task automatic simple_load(input string nm, input logic [31:0] a, input logic [W_TAG-1:0] t,
                             input logic [W_DATA-1:0] rd, input int hold);
    ld_req  = 1'b1;
    ld_addr = a;
    ld_tag  = t;
    @(negedge clk);
    check_eq({nm, "_ld_ack"}, 64'(ld_ack), 64'd1);
    check_eq({nm, "_dc_valid"}, 64'(dc_valid), 64'd1);
    check_eq({nm, "_dc_opcode"}, 64'(dc_opcode), 64'd0);
    check_eq({nm, "_dc_address"}, 64'(dc_address), 64'(a));
    ld_req   = 1'b0;
    dc_done  = 1'b1;
    dc_rdata = rd;
    @(negedge clk);
    dc_done  = 1'b0;
    dc_rdata = '0;
    check_eq({nm, "_ack_pulse"}, 64'(ld_ack), 64'd0);
    check_eq({nm, "_dc_valid_off"}, 64'(dc_valid), 64'd0);
    for (int i = 0; i <= hold; i++) begin
      check_eq({nm, "_cdb_valid"}, 64'(cdb_valid), 64'd1);
      check_eq({nm, "_cdb_data"}, 64'(cdb_data), 64'(rd));
      check_eq({nm, "_cdb_tag"}, 64'(cdb_tag), 64'(t));
      if (i == hold) cdb_grant = 1'b1;
      @(negedge clk);
    end
    cdb_grant = 1'b0;
    check_eq({nm, "_cdb_drop"}, 64'(cdb_valid), 64'd0);
    check_eq({nm, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  string order;
  string exp_order;
  bit    seen_s;
  int    guard;

  // Reference model state for the random phase
  bit                free;
  int                starve;
  bit                in_acc;
  bit                acc_st;
  bit                grant_st;
  bit                e_ld_ack;
  bit                e_st_ack;
  bit                e_cdb;
  logic [31:0]       e_addr;
  logic [W_DATA-1:0] e_data;
  logic [W_TAG-1:0]  e_tag;
  logic [W_DATA-1:0] e_cdb_data;
  logic [W_TAG-1:0]  e_cdb_tag;

  initial begin
    quiet_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_dc_valid", 64'(dc_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_ld_ack", 64'(ld_ack), 64'd0);
    check_eq("rst_st_ack", 64'(st_ack), 64'd0);
    check_eq("rst_dc_address", 64'(dc_address), 64'd0);
    check_eq("rst_cdb_data", 64'(cdb_data), 64'd0);
    check_eq("rst_starve", 64'(dut.starve_cnt_q), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    simple_load("t1", 32'h10, 6'h2A, 32'hDEADBEEF, 2);

    // Store with dc_done three cycles late
    st_req  = 1'b1;
    st_addr = 32'h20;
    st_data = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t2_dc_valid", 64'(dc_valid), 64'd1);
      check_eq("t2_dc_opcode", 64'(dc_opcode), 64'd1);
      check_eq("t2_dc_address", 64'(dc_address), 64'h20);
      check_eq("t2_dc_data", 64'(dc_data), 64'h12345678);
      check_eq("t2_st_ack", 64'(st_ack), (i == 0) ? 64'd1 : 64'd0);
      check_eq("t2_cdb_valid", 64'(cdb_valid), 64'd0);
      st_req  = 1'b0;
      dc_done = (i == 3);
    end
    @(negedge clk);
    dc_done = 1'b0;
    check_eq("t2_dc_valid_off", 64'(dc_valid), 64'd0);
    check_eq("t2_busy_off", 64'(busy), 64'd0);
    check_eq("t2_cdb_valid_off", 64'(cdb_valid), 64'd0);

    // Starvation: store waits behind exactly STARVE_MAX loads
    order     = "";
    exp_order = "LLLLS";
    seen_s    = 1'b0;
    guard     = 0;
    st_req    = 1'b1;
    st_addr   = 32'h300;
    st_data   = 32'hA5A5A5A5;
    ld_req    = 1'b1;
    ld_addr   = 32'h400;
    ld_tag    = 6'h07;
    while (!seen_s && guard < 80) begin
      @(negedge clk);
      guard++;
      dc_done   = 1'b0;
      cdb_grant = 1'b0;
      if (ld_ack) begin
        order  = {order, "L"};
        ld_req = 1'b0;
        check_eq("t3_starve_inc", 64'(dut.starve_cnt_q),
                 64'((order.len() > STARVE_MAX) ? STARVE_MAX : order.len()));
      end else if (!ld_req) begin
        ld_req = 1'b1;
      end
      if (st_ack) begin
        order  = {order, "S"};
        st_req = 1'b0;
        ld_req = 1'b0;
        seen_s = 1'b1;
        check_eq("t3_starve_clr", 64'(dut.starve_cnt_q), 64'd0);
      end
      if (dc_valid) dc_done = 1'b1;
      if (cdb_valid) cdb_grant = 1'b1;
    end
    check_eq("t3_finished", 64'(seen_s), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3_grant%0d", i), (i < order.len()) ? 64'(order[i]) : 64'd0,
               64'(exp_order[i]));
    end
    @(negedge clk);
    dc_done   = 1'b0;
    cdb_grant = 1'b0;
    check_eq("t3_idle", 64'(busy), 64'd0);
    check_eq("t3_starve_end", 64'(dut.starve_cnt_q), 64'd0);

    // Flush during ACCESS: one cycle before dc_done, then coincident with dc_done
    for (int v = 0; v < 2; v++) begin
      ld_req  = 1'b1;
      ld_addr = 32'h40;
      ld_tag  = 6'h05;
      @(negedge clk);
      check_eq("t4_ld_ack", 64'(ld_ack), 64'd1);
      ld_req = 1'b0;
      flush  = 1'b1;
      if (v == 0) begin
        @(negedge clk);
        flush = 1'b0;
        check_eq("t4_still_access", 64'(dc_valid), 64'd1);
      end
      dc_done  = 1'b1;
      dc_rdata = 32'hCAFEF00D;
      @(negedge clk);
      flush   = 1'b0;
      dc_done = 1'b0;
      check_eq($sformatf("t4_no_cdb_v%0d", v), 64'(cdb_valid), 64'd0);
      check_eq($sformatf("t4_idle_v%0d", v), 64'(busy), 64'd0);
      @(negedge clk);
      check_eq($sformatf("t4_no_cdb_late_v%0d", v), 64'(cdb_valid), 64'd0);
    end

    // Flush during RESP without cdb_grant
    ld_req  = 1'b1;
    ld_addr = 32'h44;
    ld_tag  = 6'h09;
    @(negedge clk);
    ld_req   = 1'b0;
    dc_done  = 1'b1;
    dc_rdata = 32'h0BADF00D;
    @(negedge clk);
    dc_done = 1'b0;
    check_eq("t4b_cdb_valid", 64'(cdb_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("t4b_cdb_drop", 64'(cdb_valid), 64'd0);
    check_eq("t4b_idle", 64'(busy), 64'd0);

    // Flush in IDLE with both requests: only the store is granted
    ld_req  = 1'b1;
    ld_addr = 32'h50;
    st_req  = 1'b1;
    st_addr = 32'h60;
    st_data = 32'h00C0FFEE;
    flush   = 1'b1;
    @(negedge clk);
    check_eq("t5_st_ack", 64'(st_ack), 64'd1);
    check_eq("t5_ld_ack", 64'(ld_ack), 64'd0);
    check_eq("t5_dc_opcode", 64'(dc_opcode), 64'd1);
    check_eq("t5_dc_address", 64'(dc_address), 64'h60);
    flush   = 1'b0;
    ld_req  = 1'b0;
    st_req  = 1'b0;
    dc_done = 1'b1;
    @(negedge clk);
    dc_done = 1'b0;
    check_eq("t5_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of ACCESS
    ld_req  = 1'b1;
    ld_addr = 32'h70;
    ld_tag  = 6'h01;
    @(negedge clk);
    check_eq("t6_ld_ack", 64'(ld_ack), 64'd1);
    ld_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("t6_dc_valid_async", 64'(dc_valid), 64'd0);
    check_eq("t6_busy_async", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    simple_load("t6b", 32'h80, 6'h11, 32'h5A5A1234, 0);

    // Randomized traffic against a transaction-level model (no flushes)
    quiet_inputs();
    @(negedge clk);
    free     = 1'b1;
    starve   = 0;
    in_acc   = 1'b0;
    acc_st   = 1'b0;
    e_ld_ack = 1'b0;
    e_st_ack = 1'b0;
    e_cdb    = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    e_tag    = '0;
    e_cdb_data = '0;
    e_cdb_tag  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_eq("r_ld_ack", 64'(ld_ack), 64'(e_ld_ack));
      check_eq("r_st_ack", 64'(st_ack), 64'(e_st_ack));
      check_eq("r_dc_valid", 64'(dc_valid), 64'(in_acc));
      if (in_acc) begin
        check_eq("r_dc_opcode", 64'(dc_opcode), 64'(acc_st));
        check_eq("r_dc_address", 64'(dc_address), 64'(e_addr));
        if (acc_st) check_eq("r_dc_data", 64'(dc_data), 64'(e_data));
      end
      check_eq("r_cdb_valid", 64'(cdb_valid), 64'(e_cdb));
      if (e_cdb) begin
        check_eq("r_cdb_data", 64'(cdb_data), 64'(e_cdb_data));
        check_eq("r_cdb_tag", 64'(cdb_tag), 64'(e_cdb_tag));
      end
      check_eq("r_busy", 64'(busy), 64'(in_acc || e_cdb));
      check_eq("r_starve", 64'(dut.starve_cnt_q), 64'(starve));

      if (e_ld_ack) begin
        ld_req = 1'b0;
      end else if (!ld_req && $urandom_range(0, 2) == 0) begin
        ld_req  = 1'b1;
        ld_addr = $urandom;
        ld_tag  = W_TAG'($urandom);
      end
      if (e_st_ack) begin
        st_req = 1'b0;
      end else if (!st_req && $urandom_range(0, 2) == 0) begin
        st_req  = 1'b1;
        st_addr = $urandom;
        st_data = $urandom;
      end
      e_ld_ack  = 1'b0;
      e_st_ack  = 1'b0;
      dc_done   = ($urandom_range(0, 2) == 0);
      dc_rdata  = $urandom;
      cdb_grant = ($urandom_range(0, 1) == 1);

      if (free) begin
        if (ld_req || st_req) begin
          grant_st = st_req && (!ld_req || starve == STARVE_MAX);
          free     = 1'b0;
          in_acc   = 1'b1;
          acc_st   = grant_st;
          if (grant_st) begin
            e_st_ack = 1'b1;
            e_addr   = st_addr;
            e_data   = st_data;
            starve   = 0;
          end else begin
            e_ld_ack = 1'b1;
            e_addr   = ld_addr;
            e_tag    = ld_tag;
            if (st_req) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
          end
        end
      end else if (in_acc) begin
        if (dc_done) begin
          in_acc = 1'b0;
          if (acc_st) begin
            free = 1'b1;
          end else begin
            e_cdb      = 1'b1;
            e_cdb_data = dc_rdata;
            e_cdb_tag  = e_tag;
          end
        end
      end else if (e_cdb) begin
        if (cdb_grant) begin
          e_cdb = 1'b0;
          free  = 1'b1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Sequencer and arbiter for the single-ported data cache in the load/store execution unit. Two requesters share the cache: the load issue path (speculative loads from the load/store queue) and the store retire path (committed stores from the store buffer). The arbiter grants one access at a time and drives the cache port. It holds each load result until the common data bus (CDB) accepts it, and it discards in-flight loads on a pipeline flush.

## Interface
- W_DATA, 32, data width
- W_TAG, 6, ROB/CDB tag width
- STARVE_MAX, 4, number of consecutive load grants allowed while a store waits; range 1..15

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- ld_req  in  1  load request; held high until ld_ack
- ld_addr  in  32  load address
- ld_tag  in  W_TAG  destination tag of the load
- ld_ack  out  1  one-cycle grant pulse for the load
- st_req  in  1  store request; held high until st_ack
- st_addr  in  32  store address
- st_data  in  W_DATA  store data
- st_ack  out  1  one-cycle grant pulse for the store
- flush  in  1  one-cycle pulse that kills the outstanding load
- dc_valid  out  1  cache access active
- dc_opcode  out  1  1 = write, 0 = read
- dc_address  out  32  cache address
- dc_data  out  W_DATA  cache write data
- dc_rdata  in  W_DATA  cache read data, valid while dc_done = 1
- dc_done  in  1  cache access complete
- cdb_valid  out  1  load result valid
- cdb_data  out  W_DATA  load result
- cdb_tag  out  W_TAG  load tag
- cdb_grant  in  1  CDB accepts the result this cycle
- busy  out  1  state != IDLE

## Operation
- Three states: IDLE, ACCESS, RESP. The state register and all outputs are registered.
- IDLE, neither request pending: stay in IDLE.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: grant the load, unless starve_cnt == STARVE_MAX, in which case grant the store.
- starve_cnt (4 bits):
  - +1 on a load grant while st_req = 1, saturating at STARVE_MAX
  - cleared on every store grant
- On a grant, move to ACCESS and drive the cache port:
  - register dc_address, dc_opcode, dc_data (store only) and the load tag
  - dc_valid = 1 for the whole of ACCESS
  - pulse ld_ack or st_ack for exactly the first ACCESS cycle
- ACCESS, store, dc_done = 1: return to IDLE.
- ACCESS, load, dc_done = 1, not killed: capture dc_rdata into cdb_data and the tag into cdb_tag; move to RESP.
- ACCESS, load, dc_done = 1, killed: return to IDLE with no CDB broadcast.
- ACCESS, dc_done = 0: stay in ACCESS with all port signals stable. There is no timeout.
- RESP: cdb_valid = 1, with data and tag stable. On cdb_grant = 1, move to IDLE.
- flush:
  - sets the kill flag if a load is in ACCESS, including when it coincides with dc_done
  - in RESP: drop to IDLE and deassert cdb_valid next cycle, regardless of cdb_grant
  - in IDLE: the load is not granted that cycle; a pending store may still be granted
  - never affects stores
  - the kill flag clears on entering IDLE

## Timing
- Reset (reset = 0, asynchronous): state IDLE; starve_cnt 0; kill flag 0; every output 0.
- Reset mid-access abandons the access immediately: dc_valid falls without waiting for clk.
- Load, minimum latency: request sampled at edge N; ld_ack and dc_valid high in cycle N+1; dc_done in N+1; cdb_valid high from N+2 until the edge where cdb_grant = 1. Minimum 3 cycles per load.
- Store, minimum latency: st_ack and dc_valid in N+1; dc_done in N+1; IDLE at N+2. Minimum 2 cycles per store.
- Requesters drop req in the cycle after ack. The earliest next IDLE sample is after dc_done, so a request is never granted twice.
- Back-to-back: a request pending on the edge of the IDLE return cycle is granted with no bubble beyond IDLE itself.
- dc_done is ignored outside ACCESS.
- cdb_grant is ignored outside RESP.

## Test plan
- Reset, then a single load (addr 0x10, tag 0x2A), with dc_done in the first ACCESS cycle and dc_rdata = 0xDEADBEEF:
  - ld_ack pulses 1 cycle
  - cdb_valid = 1 with cdb_data 0xDEADBEEF and cdb_tag 0x2A until cdb_grant
  - busy falls the cycle after cdb_grant
- Store (addr 0x20, data 0x12345678), with dc_done delayed 3 cycles:
  - dc_valid = 1, dc_opcode = 1, address and data stable for 4 cycles
  - st_ack only in the first of those cycles
  - no cdb_valid
- st_req held high continuously with ld_req re-asserted after every ld_ack, STARVE_MAX = 4:
  - grant order L, L, L, L, S
  - starve_cnt returns to 0 after the store grant
- Load in ACCESS, flush pulsed 1 cycle before dc_done: no cdb_valid; IDLE after dc_done. Repeat with flush in RESP while cdb_grant = 0: cdb_valid falls the next cycle.
- ld_req and flush in the same IDLE cycle, with st_req = 1: the store is granted, the load is not.
- reset driven to 0 mid-ACCESS, between clock edges: dc_valid and busy go to 0 immediately, without waiting for a clk edge. After release, a new load completes normally.
